// File: rtl/inv_subbytes_seq_pkg.sv
// Shared widths and FSM encoding for the time-multiplexed
// inverse SubBytes engine.
package inv_subbytes_seq_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/inv_subbytes_seq_sbox.sv
// AES inverse S-box: combinational 8-bit lookup.
// Byte-in/byte-out lane shared by the sequential engine.
module Inv_SBox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [7:0] LUT [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };

  assign dout = LUT[din];
endmodule

// File: rtl/inv_subbytes_seq.sv
// Time-multiplexed inverse SubBytes: NUM_SBOX shared lanes
// walk the captured state in 16/NUM_SBOX chunks.
module inv_subbytes_seq
  import inv_subbytes_seq_pkg::*;
#(
  parameter int NUM_SBOX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] dataIn,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] dataOut,
  output logic                   busy
);
  localparam int NCYC  = AES_NBYTES / NUM_SBOX;
  localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

  if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
      NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
    $error("inv_subbytes_seq: NUM_SBOX must be 1, 2, 4, 8 or 16");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] src_q, src_d;
  logic [AES_STATE_W-1:0] res_q, res_d;

  logic [AES_BYTE_W-1:0]  lane_in  [NUM_SBOX];
  logic [AES_BYTE_W-1:0]  lane_out [NUM_SBOX];
  int                     base;

  // First byte handled by lane 0 in the current chunk.
  assign base = int'(cnt_q) * NUM_SBOX;

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
    assign lane_in[j] =
      src_q[AES_BYTE_W*(base+j) +: AES_BYTE_W];

    Inv_SBox u_sbox (
      .din  (lane_in[j]),
      .dout (lane_out[j])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          src_d   = dataIn;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int k = 0; k < NUM_SBOX; k++) begin
          res_d[AES_BYTE_W*(base+k) +: AES_BYTE_W] = lane_out[k];
        end
        if (cnt_q == CNT_W'(NCYC-1)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        // Accept the next block on the same edge the result leaves.
        if (out_ready) begin
          if (in_valid) begin
            src_d   = dataIn;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE) ||
                     ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY);
  assign dataOut   = res_q;
endmodule
